ahb_rom_ctrl: RTL and testbench
===============================

// Module: ahb_rom_ctrl
// PURPOSE
//  Parametrised AHB slave controller for a single-port synchronous ROM macro (registered output,
//  1-cycle read latency). Next-generation boot ROM path: configurable width, depth and wait
//  states, with ERROR responses for writes, out-of-range and oversize accesses. Sits on the AHB
//  slave mux; the ROM macro wrapper connects directly to the rom_* ports.
// PARAMETERS
//  DATA_WIDTH   32   ROM/AHB data width, 32 or 64; BOFF = log2(DATA_WIDTH/8)
//  DEPTH        512  ROM words, 2..65536, need not be a power of 2; AW = clog2(DEPTH)
//  RANGE_MSB    15   top haddr bit of the decoded region (64 KB window)
//  WAIT_STATES  0    extra data-phase wait cycles per read, 0..7
//  ERR_ON_WRITE 1    1: writes get ERROR; 0: writes complete OKAY, zero wait, are discarded
// PORTS
//  hclk       in   1           AHB clock
//  n_hreset   in   1           async active-low reset
//  hsel       in   1           slave select
//  haddr      in   32          address
//  htrans     in   2           transfer type (IDLE/BUSY/NONSEQ/SEQ)
//  hsize      in   3           transfer size
//  hwrite     in   1           write strobe
//  hready_in  in   1           combined bus hready
//  hrdata     out  DATA_WIDTH  read data
//  hready     out  1           slave ready
//  hresp      out  2           00 OKAY, 01 ERROR
//  rom_me     out  1           ROM memory enable, active high
//  rom_adr    out  AW          ROM word address
//  rom_q      in   DATA_WIDTH  ROM data, valid the cycle after rom_me
// BEHAVIOUR
//  Clock hclk; reset n_hreset asynchronous, active-low. In reset: state IDLE, hready=1,
//   hresp=00, hrdata=0, rom_me=0, wait counter=0.
//  Accept = hsel & hready_in & htrans[1] (NONSEQ or SEQ, treated alike). IDLE/BUSY, or hsel=0:
//   no action, OKAY, zero wait.
//  Error condition on accept: (hwrite & ERR_ON_WRITE) | hsize > BOFF
//   | haddr[RANGE_MSB:BOFF] >= DEPTH. Alignment is not checked; low address bits are ignored.
//  Address phase (combinational): rom_me = accept & ~hwrite & ~error & n_hreset;
//   rom_adr = haddr[BOFF+AW-1:BOFF]. rom_me=0 never creates a ROM access.
//  FSM:
//   IDLE:  hready=1, hresp=00. A good read moves to RD. An error moves to ERR1.
//          A write with ERR_ON_WRITE=0 stays in IDLE.
//   RD:    data phase. In cycle 1 rom_q is captured into rdata_q. Wait counter loads
//          WAIT_STATES; hready=0 while counter != 0, decrementing each cycle. On the final
//          cycle hready=1 and hresp=00. hrdata = rom_q when WAIT_STATES=0, else rdata_q.
//          Read latency is WAIT_STATES+1 cycles from address phase to hready=1.
//   ERR1:  hready=0, hresp=01 -> ERR2.
//   ERR2:  hready=1, hresp=01.
//  Pipelining: on the final RD cycle and in ERR2 (hready=1), a new accept is decoded as in
//   IDLE and goes directly to RD/ERR1/IDLE, giving back-to-back transfers with no bubble.
//  hrdata is 0 in every cycle except a read data phase with hready=1.
//  hready_in=0 with hsel=1: not an accept, state unchanged. This slave never stalls another
//   slave's data phase.
//  Reset asserted mid-transfer: all state is cleared immediately. The access in flight is
//   abandoned and no response completes.
// TESTING
//  1. WAIT_STATES=0, DEPTH=512: read at 0x0000_07FC -> rom_adr=511, rom_me=1 for 1 cycle;
//     next cycle hready=1, hrdata=rom_q, hresp=00.
//  2. WAIT_STATES=2: NONSEQ+3 SEQ burst from 0x0 -> each beat has hready=0,0,1 with data
//     for words 0..3 and no idle cycle between beats.
//  3. Write to 0x10 -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01), rom_me
//     never set. ERR_ON_WRITE=0: OKAY with zero wait.
//  4. Read at 0x800 (word 512 >= DEPTH) or hsize=3 with DATA_WIDTH=32 -> 2-cycle ERROR;
//     a read accepted in ERR2 completes normally.
//  5. hready_in=0 with hsel=1 and htrans=NONSEQ -> rom_me=0, no state change.
//     htrans=BUSY -> OKAY, zero wait.
//  6. Drop n_hreset during an RD wait (WAIT_STATES=3) -> outputs immediately take their
//     reset values; after release, a fresh read works.

Source files
------------

// File: rtl/ahb_rom_ctrl.sv
// AHB slave front-end for a synchronous single-port ROM macro.
// Handles wait states, pipelined reads and two-cycle ERROR responses.
module ahb_rom_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 512,
  parameter int RANGE_MSB    = 15,
  parameter int WAIT_STATES  = 0,
  parameter int ERR_ON_WRITE = 1,
  localparam int BOFF = $clog2(DATA_WIDTH/8),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  hclk,
  input  logic                  n_hreset,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic                  hready_in,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic                  rom_me,
  output logic [AW-1:0]         rom_adr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam logic [2:0]  WS3     = 3'(WAIT_STATES);
  localparam logic [2:0]  SZ_MAX  = 3'(BOFF);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic        WR_ERR  = 1'(ERR_ON_WRITE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [2:0]            cnt;
  logic [2:0]            cnt_n;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [31:0]           word_idx;
  logic                  accept;
  logic                  err;
  logic                  rd_ok;
  logic                  last;
  logic                  slot;
  logic                  unused_bits;

  assign word_idx = 32'(haddr[RANGE_MSB:BOFF]);
  assign accept   = hsel & hready_in & htrans[1];
  assign err      = accept & ((hwrite & WR_ERR)
                  | (hsize > SZ_MAX)
                  | (word_idx >= DEPTH_W));
  assign rd_ok    = accept & ~hwrite & ~err;

  assign rom_me  = rd_ok & n_hreset;
  assign rom_adr = haddr[BOFF+AW-1:BOFF];

  // A new address phase may be decoded whenever this slave shows hready=1.
  assign last = (state == S_RD) & (cnt == 3'd0);
  assign slot = (state == S_IDLE) | last | (state == S_ERR2);

  assign unused_bits = ^{haddr, htrans[0]};

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_RD && cnt == WS3)
        rdata_q <= rom_q;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_RD:    if (cnt != 3'd0) cnt_n = cnt - 3'd1;
      S_ERR1:  state_n = S_ERR2;
      default: ;
    endcase
    if (slot) begin
      cnt_n = rd_ok ? WS3 : 3'd0;
      unique case (1'b1)
        err:     state_n = S_ERR1;
        rd_ok:   state_n = S_RD;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = '0;
    unique case (state)
      S_RD: begin
        hready = last;
        if (last)
          hrdata = (WAIT_STATES == 0) ? rom_q : rdata_q;
      end
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 2'b01;
      end
      S_ERR2:  hresp = 2'b01;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_rom_ctrl.sv
// Bench for ahb_rom_ctrl: three instances (0/2/3 wait states),
// transfer-level reference model plus directed hand checks.
module tb_ahb_rom_ctrl;

  logic        hclk = 1'b0;
  logic        rst_n;
  logic        hsel      [3];
  logic        hwrite    [3];
  logic        hready_in [3];
  logic        hold_low  [3];
  logic        hready    [3];
  logic        rom_me    [3];
  logic [31:0] haddr     [3];
  logic [31:0] hrdata    [3];
  logic [31:0] rom_q     [3];
  logic [1:0]  htrans    [3];
  logic [1:0]  hresp     [3];
  logic [2:0]  hsize     [3];
  logic [8:0]  rom_adr   [3];

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  bit done  = 0;

  int         kind [3] = '{0, 0, 0};
  int         left [3] = '{0, 0, 0};
  logic [8:0] word [3] = '{9'd0, 9'd0, 9'd0};

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  assign hready_in[0] = hold_low[0] ? 1'b0 : hready[0];
  assign hready_in[1] = hold_low[1] ? 1'b0 : hready[1];
  assign hready_in[2] = hold_low[2] ? 1'b0 : hready[2];

  ahb_rom_ctrl #(.WAIT_STATES(0), .ERR_ON_WRITE(1)) u0 (
    .hclk(hclk), .n_hreset(rst_n), .hsel(hsel[0]),
    .haddr(haddr[0]), .htrans(htrans[0]), .hsize(hsize[0]),
    .hwrite(hwrite[0]), .hready_in(hready_in[0]),
    .hrdata(hrdata[0]), .hready(hready[0]), .hresp(hresp[0]),
    .rom_me(rom_me[0]), .rom_adr(rom_adr[0]), .rom_q(rom_q[0])
  );

  ahb_rom_ctrl #(.WAIT_STATES(2), .ERR_ON_WRITE(0)) u1 (
    .hclk(hclk), .n_hreset(rst_n), .hsel(hsel[1]),
    .haddr(haddr[1]), .htrans(htrans[1]), .hsize(hsize[1]),
    .hwrite(hwrite[1]), .hready_in(hready_in[1]),
    .hrdata(hrdata[1]), .hready(hready[1]), .hresp(hresp[1]),
    .rom_me(rom_me[1]), .rom_adr(rom_adr[1]), .rom_q(rom_q[1])
  );

  ahb_rom_ctrl #(.WAIT_STATES(3), .ERR_ON_WRITE(1)) u2 (
    .hclk(hclk), .n_hreset(rst_n), .hsel(hsel[2]),
    .haddr(haddr[2]), .htrans(htrans[2]), .hsize(hsize[2]),
    .hwrite(hwrite[2]), .hready_in(hready_in[2]),
    .hrdata(hrdata[2]), .hready(hready[2]), .hresp(hresp[2]),
    .rom_me(rom_me[2]), .rom_adr(rom_adr[2]), .rom_q(rom_q[2])
  );

  function automatic logic [31:0] rom_word(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  function automatic int ws(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic logic bad(input int i, input logic w,
                               input logic [2:0] sz, input logic [31:0] a);
    logic [13:0] idx;
    idx = a[15:2];
    return (w && i != 1) || (sz > 3'd2) || (idx >= 14'd512);
  endfunction

  // ROM macro: registered output, garbage when not enabled.
  always @(posedge hclk)
    for (int i = 0; i < 3; i++)
      rom_q[i] <= rom_me[i] ? rom_word(rom_adr[i]) : 32'hDEAD_BEEF;

  // Reference model: kind 0 none, 1 read, 2 error; left = data cycles remaining.
  always @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        kind[i] <= 0;
        left[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (kind[i] != 0 && left[i] > 1) begin
          left[i] <= left[i] - 1;
        end else if (hsel[i] && hready_in[i] && htrans[i][1]) begin
          if (bad(i, hwrite[i], hsize[i], haddr[i])) begin
            kind[i] <= 2;
            left[i] <= 2;
          end else if (!hwrite[i]) begin
            kind[i] <= 1;
            left[i] <= ws(i) + 1;
            word[i] <= haddr[i][10:2];
          end else begin
            kind[i] <= 0;
            left[i] <= 0;
          end
        end else begin
          kind[i] <= 0;
          left[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge hclk) begin
    logic        rdy_e;
    logic        me_e;
    logic [1:0]  rsp_e;
    logic [31:0] rd_e;
    if (!done) begin
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          rdy_e = 1'b1;
          rsp_e = 2'b00;
          rd_e  = 32'd0;
          me_e  = 1'b0;
        end else begin
          rdy_e = (kind[i] == 0) || (left[i] == 1);
          rsp_e = (kind[i] == 2) ? 2'b01 : 2'b00;
          rd_e  = (kind[i] == 1 && left[i] == 1) ? rom_word(word[i]) : 32'd0;
          me_e  = hsel[i] && hready_in[i] && htrans[i][1] && !hwrite[i]
                  && !bad(i, hwrite[i], hsize[i], haddr[i]);
        end
        chk($sformatf("u%0d_hready", i), {31'd0, hready[i]}, {31'd0, rdy_e});
        chk($sformatf("u%0d_hresp", i), {30'd0, hresp[i]}, {30'd0, rsp_e});
        chk($sformatf("u%0d_hrdata", i), hrdata[i], rd_e);
        chk($sformatf("u%0d_rom_me", i), {31'd0, rom_me[i]}, {31'd0, me_e});
        if (me_e)
          chk($sformatf("u%0d_rom_adr", i), {23'd0, rom_adr[i]},
              {23'd0, haddr[i][10:2]});
      end
    end
  end

  task automatic sync;
    @(posedge hclk);
    #1;
  endtask

  task automatic go_idle(input int i);
    hsel[i]   = 1'b0;
    htrans[i] = 2'b00;
    hwrite[i] = 1'b0;
    hsize[i]  = 3'd2;
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [1:0] tr);
    hsel[i]   = 1'b1;
    haddr[i]  = a;
    hwrite[i] = w;
    hsize[i]  = sz;
    htrans[i] = tr;
  endtask

  task automatic xfer(input int i, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [1:0] tr);
    int n;
    n = 0;
    drive(i, a, w, sz, tr);
    @(negedge hclk);
    while (!hready_in[i] && n < 20) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 20) begin
      ntot++;
      $display("FAIL xfer_timeout u%0d: waited %0d cycles, limit 20", i, n);
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_ready(input int i, output int n);
    n = 1;
    @(negedge hclk);
    while (!hready[i] && n < 20) begin
      n++;
      @(negedge hclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n;
    for (int i = 0; i < 3; i++) begin
      hold_low[i] = 1'b0;
      haddr[i]    = 32'd0;
      go_idle(i);
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready", {31'd0, hready[2]}, 32'd1);
    chk("rst_hrdata", hrdata[0], 32'd0);
    rst_n = 1'b1;
    sync;

    // Last valid word, zero wait states
    drive(0, 32'h0000_07FC, 1'b0, 3'd2, 2'b10);
    @(negedge hclk);
    chk("t1_rom_me", {31'd0, rom_me[0]}, 32'd1);
    chk("t1_rom_adr", {23'd0, rom_adr[0]}, 32'd511);
    sync;
    go_idle(0);
    @(negedge hclk);
    chk("t1_hready", {31'd0, hready[0]}, 32'd1);
    chk("t1_hrdata", hrdata[0], 32'hC0DE_01FF);
    chk("t1_rom_me_off", {31'd0, rom_me[0]}, 32'd0);

    // Four-beat burst with two wait states
    sync;
    xfer(1, 32'h0, 1'b0, 3'd2, 2'b10);
    c0 = cyc;
    xfer(1, 32'h4, 1'b0, 3'd2, 2'b11);
    xfer(1, 32'h8, 1'b0, 3'd2, 2'b11);
    xfer(1, 32'hC, 1'b0, 3'd2, 2'b11);
    go_idle(1);
    wait_ready(1, n);
    chk("t2_burst_cycles", cyc - c0, 32'd11);
    chk("t2_last_data", hrdata[1], 32'hC0DE_0003);

    // Write error, and discarded write when writes are allowed
    sync;
    xfer(0, 32'h10, 1'b1, 3'd2, 2'b10);
    go_idle(0);
    @(negedge hclk);
    chk("t3_err1_ready", {31'd0, hready[0]}, 32'd0);
    chk("t3_err1_resp", {30'd0, hresp[0]}, 32'd1);
    @(negedge hclk);
    chk("t3_err2_ready", {31'd0, hready[0]}, 32'd1);
    chk("t3_err2_resp", {30'd0, hresp[0]}, 32'd1);
    sync;
    xfer(1, 32'h10, 1'b1, 3'd2, 2'b10);
    go_idle(1);
    @(negedge hclk);
    chk("t3_wr_ok_ready", {31'd0, hready[1]}, 32'd1);
    chk("t3_wr_ok_resp", {30'd0, hresp[1]}, 32'd0);

    // Out of range, then a read accepted in ERR2; oversize access
    sync;
    xfer(0, 32'h800, 1'b0, 3'd2, 2'b10);
    xfer(0, 32'h4, 1'b0, 3'd2, 2'b10);
    go_idle(0);
    @(negedge hclk);
    chk("t4_after_err_ready", {31'd0, hready[0]}, 32'd1);
    chk("t4_after_err_data", hrdata[0], 32'hC0DE_0001);
    sync;
    xfer(0, 32'h0, 1'b0, 3'd3, 2'b10);
    go_idle(0);
    @(negedge hclk);
    chk("t4_size_resp", {30'd0, hresp[0]}, 32'd1);
    chk("t4_size_ready", {31'd0, hready[0]}, 32'd0);

    // hready_in low, then BUSY
    sync;
    hold_low[0] = 1'b1;
    drive(0, 32'h20, 1'b0, 3'd2, 2'b10);
    @(negedge hclk);
    chk("t5_hold_rom_me", {31'd0, rom_me[0]}, 32'd0);
    sync;
    hold_low[0] = 1'b0;
    go_idle(0);
    @(negedge hclk);
    chk("t5_hold_ready", {31'd0, hready[0]}, 32'd1);
    sync;
    drive(0, 32'h20, 1'b0, 3'd2, 2'b01);
    @(negedge hclk);
    chk("t5_busy_rom_me", {31'd0, rom_me[0]}, 32'd0);
    sync;
    go_idle(0);
    @(negedge hclk);
    chk("t5_busy_ready", {31'd0, hready[0]}, 32'd1);
    chk("t5_busy_resp", {30'd0, hresp[0]}, 32'd0);

    // Reset during a wait-state read
    sync;
    xfer(2, 32'h40, 1'b0, 3'd2, 2'b10);
    drive(2, 32'h44, 1'b0, 3'd2, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", {31'd0, hready[2]}, 32'd1);
    chk("t6_rst_resp", {30'd0, hresp[2]}, 32'd0);
    chk("t6_rst_hrdata", hrdata[2], 32'd0);
    chk("t6_rst_rom_me", {31'd0, rom_me[2]}, 32'd0);
    go_idle(2);
    @(posedge hclk);
    @(posedge hclk);
    #2 rst_n = 1'b1;
    sync;
    xfer(2, 32'h44, 1'b0, 3'd2, 2'b10);
    go_idle(2);
    wait_ready(2, n);
    chk("t6_latency", n, 32'd4);
    chk("t6_data", hrdata[2], 32'hC0DE_0011);

    sync;
    repeat (3) sync;
    done = 1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
